cycle_tracer: RTL and testbench



---
 rtl/cycle_tracer.sv | 163 ++++++++++++++++
 tb/tb_cycle_tracer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_tracer.sv
// Negative-cycle detector: one extra Bellman-Ford relaxation pass, then a
// predecessor walk onto the cycle and a valid/ready stream of its vertices.
module cycle_tracer #(
    parameter int NODES    = 8,
    parameter int IDX_W    = 3,
    parameter int WEIGHT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic [IDX_W-1:0]          vertmat_addr,
    input  logic [IDX_W+WEIGHT_W-1:0] vertmat_q,
    output logic [IDX_W-1:0]          adjmat_row_addr,
    output logic [IDX_W-1:0]          adjmat_col_addr,
    input  logic [WEIGHT_W-1:0]       adjmat_q,
    output logic                      path_valid,
    input  logic                      path_ready,
    output logic [IDX_W-1:0]          path_node,
    output logic                      path_last,
    output logic                      found,
    output logic                      error,
    output logic                      done,
    output logic [3:0]                dbg_state
);

    // Handshake: a node transfers on a cycle where path_valid && path_ready;
    // path_node/path_last hold and path_valid stays high until that happens.

    typedef enum logic [3:0] {
        S_IDLE, S_CHK_SRC, S_CHK_DST, S_CHK_CMP, S_WALK_RD, S_WALK_UPD,
        S_EMIT_OUT, S_EMIT_RD1, S_EMIT_RD2, S_DONE
    } state_t;

    localparam logic [WEIGHT_W-1:0] INF      = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NODES - 1);
    localparam logic [IDX_W:0]      CNT_LAST = (IDX_W+1)'(NODES - 1);

    state_t                state, next_state;
    logic [IDX_W-1:0]      i, j, v, anchor, nxt;
    logic [IDX_W:0]        walk_cnt, emit_cnt;
    logic [WEIGHT_W-1:0]   svw;
    logic [IDX_W-1:0]      q_pred;
    logic [WEIGHT_W-1:0]   q_w;
    logic signed [WEIGHT_W:0] sum_w, dst_w;
    logic                  witness, last_pair, xfer, walk_end, emit_full;

    assign q_pred    = vertmat_q[IDX_W+WEIGHT_W-1:WEIGHT_W];
    assign q_w       = vertmat_q[WEIGHT_W-1:0];
    // Widened by one bit so INF-adjacent sums cannot wrap.
    assign sum_w     = {svw[WEIGHT_W-1], svw} + {adjmat_q[WEIGHT_W-1], adjmat_q};
    assign dst_w     = {q_w[WEIGHT_W-1], q_w};
    assign witness   = (adjmat_q != '0) && (svw != INF) && (sum_w < dst_w);
    assign last_pair = (i == IDX_LAST) && (j == IDX_LAST);
    assign xfer      = (state == S_EMIT_OUT) && path_ready;
    assign walk_end  = (walk_cnt == CNT_LAST);
    assign emit_full = (emit_cnt == CNT_LAST);

    assign adjmat_row_addr = i;
    assign adjmat_col_addr = j;
    assign dbg_state       = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_CHK_SRC;
            S_CHK_SRC:  next_state = S_CHK_DST;
            S_CHK_DST:  next_state = S_CHK_CMP;
            S_CHK_CMP: begin
                if (witness)        next_state = S_WALK_RD;
                else if (last_pair) next_state = S_DONE;
                else                next_state = S_CHK_SRC;
            end
            S_WALK_RD:  next_state = S_WALK_UPD;
            // The final walk step already points the memory at the anchor,
            // so the anchor's own path_last is resolved in EMIT_RD2.
            S_WALK_UPD: next_state = walk_end ? S_EMIT_RD2 : S_WALK_RD;
            S_EMIT_OUT: begin
                if (xfer) next_state = (path_last || emit_full) ? S_DONE : S_EMIT_RD1;
            end
            S_EMIT_RD1: next_state = S_EMIT_RD2;
            S_EMIT_RD2: next_state = S_EMIT_OUT;
            S_DONE:     if (start) next_state = S_CHK_SRC;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        path_valid   = (state == S_EMIT_OUT);
        done         = (state == S_DONE);
        vertmat_addr = '0;
        case (state)
            S_CHK_SRC:  vertmat_addr = i;
            S_CHK_DST:  vertmat_addr = j;
            S_WALK_RD:  vertmat_addr = v;
            S_WALK_UPD: vertmat_addr = q_pred;
            S_EMIT_OUT: vertmat_addr = path_node;
            S_EMIT_RD1: vertmat_addr = q_pred;
            default:    vertmat_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i <= '0; j <= '0; v <= '0; anchor <= '0; nxt <= '0;
            walk_cnt <= '0; emit_cnt <= '0; svw <= '0;
            path_node <= '0; path_last <= 1'b0; found <= 1'b0; error <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        i <= '0; j <= '0;
                        found <= 1'b0; error <= 1'b0;
                        path_node <= '0; path_last <= 1'b0;
                    end
                end
                S_CHK_DST: svw <= q_w;
                S_CHK_CMP: begin
                    if (witness) begin
                        v        <= j;
                        walk_cnt <= '0;
                    end else if (!last_pair) begin
                        j <= (j == IDX_LAST) ? '0 : j + 1'b1;
                        if (j == IDX_LAST) i <= i + 1'b1;
                    end else begin
                        found <= 1'b0;
                    end
                end
                S_WALK_UPD: begin
                    v        <= q_pred;
                    walk_cnt <= walk_cnt + 1'b1;
                    if (walk_end) begin
                        anchor   <= q_pred;
                        nxt      <= q_pred;
                        emit_cnt <= '0;
                    end
                end
                S_EMIT_OUT: begin
                    if (xfer) begin
                        emit_cnt <= emit_cnt + 1'b1;
                        if (path_last) begin
                            found <= 1'b1;
                        end else if (emit_full) begin
                            error <= 1'b1;
                            found <= 1'b0;
                        end
                    end
                end
                S_EMIT_RD1: nxt <= q_pred;
                S_EMIT_RD2: begin
                    path_node <= nxt;
                    path_last <= (q_pred == anchor);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_tracer.sv
// Directed bench for cycle_tracer at NODES=4 with modelled vertex/adjacency
// memories and a scoreboard of expected {last,node} pairs.
module tb_cycle_tracer;

    localparam int NODES    = 4;
    localparam int IDX_W    = 2;
    localparam int WEIGHT_W = 32;
    localparam logic [WEIGHT_W-1:0] INF = 32'h7fff_ffff;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      start = 1'b0;
    logic [IDX_W-1:0]          vertmat_addr;
    logic [IDX_W+WEIGHT_W-1:0] vertmat_q;
    logic [IDX_W-1:0]          adjmat_row_addr, adjmat_col_addr;
    logic [WEIGHT_W-1:0]       adjmat_q;
    logic                      path_valid;
    logic                      path_ready = 1'b1;
    logic [IDX_W-1:0]          path_node;
    logic                      path_last, found, error, done;
    logic [3:0]                dbg_state;

    cycle_tracer #(.NODES(NODES), .IDX_W(IDX_W), .WEIGHT_W(WEIGHT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .vertmat_addr(vertmat_addr), .vertmat_q(vertmat_q),
        .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr),
        .adjmat_q(adjmat_q), .path_valid(path_valid), .path_ready(path_ready),
        .path_node(path_node), .path_last(path_last), .found(found),
        .error(error), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory models (1-cycle synchronous read) ----------------
    logic [IDX_W+WEIGHT_W-1:0] vmem [NODES];
    logic [WEIGHT_W-1:0]       amem [NODES][NODES];

    always @(posedge clk) begin
        vertmat_q <= vmem[vertmat_addr];
        adjmat_q  <= amem[adjmat_row_addr][adjmat_col_addr];
    end

    // ---------------- scoreboard ----------------
    logic [IDX_W:0] exp_q[$];
    int chk_cnt = 0;
    int err_cnt = 0;
    int n_xfer  = 0;
    int cyc;
    int bp_mode = 0;
    int hold    = 0;
    logic hold_pending = 1'b0;
    logic [IDX_W:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops on every transfer, checks hold stability under backpressure.
    always @(negedge clk) begin
        logic [IDX_W:0] e;
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(path_valid), 64'd1);
                check("hold_node", 64'({path_last, path_node}), 64'(held));
            end
            if (path_valid && path_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("unexpected_node", 64'({path_last, path_node}), 64'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("path_node", 64'(path_node), 64'(e[IDX_W-1:0]));
                    check("path_last", 64'(path_last), 64'(e[IDX_W]));
                end
            end
            hold_pending = path_valid && !path_ready;
            held = {path_last, path_node};
        end
    end

    // Ready driver: always ready, or in backpressure mode low for 5 valid cycles per node.
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) begin
            path_ready = 1'b1;
        end else if (path_ready) begin
            path_ready = 1'b0;
            hold = 0;
        end else if (path_valid) begin
            hold++;
            if (hold >= 5) path_ready = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mems();
        for (int r = 0; r < NODES; r++) begin
            vmem[r] = '0;
            for (int c = 0; c < NODES; c++) amem[r][c] = '0;
        end
    endtask

    task automatic load_s1();
        clear_mems();
        vmem[0] = {2'd0, 32'd0}; vmem[1] = {2'd0, 32'd5};
        vmem[2] = {2'd1, 32'd4}; vmem[3] = {2'd2, 32'd6};
        amem[0][1] = 32'd5; amem[1][2] = -32'sd1; amem[2][3] = 32'd2;
    endtask

    task automatic load_s2();
        clear_mems();
        vmem[0] = {2'd0, 32'd0}; vmem[1] = {2'd3, 32'd2};
        vmem[2] = {2'd1, 32'd1}; vmem[3] = {2'd2, 32'd0};
        amem[0][1] = 32'd5; amem[1][2] = -32'sd1;
        amem[2][3] = -32'sd1; amem[3][1] = -32'sd1;
    endtask

    // Vertex 3 unreached; its out-edges must be skipped. 3->1 is the most
    // negative weight, so INF + weight = -1 < 5 would fire if not skipped.
    // 2->3 is dropped since it would legitimately relax the INF vertex.
    task automatic load_s4();
        load_s1();
        amem[2][3] = '0;
        vmem[3] = {2'd0, INF};
        amem[3][0] = -32'sd100;
        amem[3][1] = 32'h8000_0000;
    endtask

    task automatic push_cycle();
        exp_q.push_back({1'b0, 2'd3});
        exp_q.push_back({1'b0, 2'd2});
        exp_q.push_back({1'b1, 2'd1});
    endtask

    // Start is launched just after a rising edge; cyc counts edges from that one.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int budget);
        while (!done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!path_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 64'(path_valid), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(path_valid), 64'd0);
        check({tag, "_node"},  64'(path_node),  64'd0);
        check({tag, "_last"},  64'(path_last),  64'd0);
        check({tag, "_found"}, 64'(found),      64'd0);
        check({tag, "_error"}, 64'(error),      64'd0);
        check({tag, "_done"},  64'(done),       64'd0);
        check({tag, "_addr"},  64'(vertmat_addr), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_mems();
        repeat (3) @(posedge clk);
        #2 check_all_zero("reset");
        check("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // 1: no cycle, latency 3*N*N+1
        load_s1(); n_xfer = 0;
        pulse_start();
        wait_done(200);
        check("s1_latency", 64'(cyc), 64'd49);
        check("s1_found", 64'(found), 64'd0);
        check("s1_error", 64'(error), 64'd0);
        check("s1_xfers", 64'(n_xfer), 64'd0);

        // 2: negative cycle 3 -> 2 -> 1
        load_s2(); n_xfer = 0; push_cycle();
        pulse_start();
        wait_done(400);
        check("s2_found", 64'(found), 64'd1);
        check("s2_error", 64'(error), 64'd0);
        check("s2_xfers", 64'(n_xfer), 64'd3);
        check("s2_queue", 64'(exp_q.size()), 64'd0);

        // 3: backpressure; a stray start mid-emit must be ignored
        bp_mode = 1;
        n_xfer = 0; push_cycle();
        pulse_start();
        wait_valid(300);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(600);
        check("s3_found", 64'(found), 64'd1);
        check("s3_xfers", 64'(n_xfer), 64'd3);
        check("s3_queue", 64'(exp_q.size()), 64'd0);
        bp_mode = 0;
        repeat (2) @(posedge clk);

        // 4: unreached source skipped
        load_s4(); n_xfer = 0;
        pulse_start();
        wait_done(200);
        check("s4_latency", 64'(cyc), 64'd49);
        check("s4_found", 64'(found), 64'd0);
        check("s4_xfers", 64'(n_xfer), 64'd0);

        // 5: asynchronous reset while the second node is offered
        load_s2(); n_xfer = 0; push_cycle();
        pulse_start();
        begin
            int n = 0;
            while (!(n_xfer == 1 && path_valid) && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check("s5_second_node", 64'(n_xfer == 1 && path_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("s5_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        n_xfer = 0; push_cycle();
        pulse_start();
        wait_done(400);
        check("s5_found", 64'(found), 64'd1);
        check("s5_xfers", 64'(n_xfer), 64'd3);

        // 6: predecessor chain corrupted once the anchor is emitted
        load_s2(); n_xfer = 0;
        exp_q.push_back({1'b0, 2'd3});
        exp_q.push_back({1'b0, 2'd2});
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd2});
        pulse_start();
        wait_valid(400);
        vmem[1] = {2'd2, 32'd2};
        wait_done(400);
        check("s6_error", 64'(error), 64'd1);
        check("s6_found", 64'(found), 64'd0);
        check("s6_xfers", 64'(n_xfer), 64'd4);
        repeat (3) @(posedge clk);
        #1 check("s6_error_stable", 64'(error), 64'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
